muldiv_seq: RTL



---
 rtl/muldiv_seq.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV32M multiply/divide unit for the execute stage. One shared
// 2*WIDTH-bit accumulator is used either as a shift-add product register
// (MUL, MULH, MULHSU, MULHU) or as a restoring-division remainder/quotient
// pair (DIV, DIVU, REM, REMU). Every operation has the same latency:
// one PREP cycle, WIDTH ITER cycles and one FIN cycle. During FIN the
// result is presented for exactly one cycle.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset (priority over everything)
//   start      valid M-extension instruction present in execute
//   kill       pipeline flush; aborts an in-flight operation
//   funct3     op select: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op_a       rs1 value
//   op_b       rs2 value
//   rd_in      destination register
//   busy       FSM not in IDLE
//   stall      freeze front end and execute stage
//   done       one-cycle result-valid pulse
//   result     final value, valid while done=1 (0 otherwise)
//   rd_out     latched destination register, valid while done=1
//   reg_write  done & (rd_out != 0)
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             reg_write
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Operands latched at acceptance; they stay stable for the whole operation.
  logic [2:0]         lat_funct3;
  logic [WIDTH-1:0]   lat_a;
  logic [WIDTH-1:0]   lat_b;
  logic [4:0]         lat_rd;

  // Shared datapath state.
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   addend;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] acc;      // {hi, lo}: product, or {remainder, quotient}
  logic [CW-1:0]      count;

  // ---------------------------------------------------------------------------
  // Operand decode and magnitudes (used in PREP)
  // ---------------------------------------------------------------------------
  logic             is_div;
  logic             signed_a;
  logic             signed_b;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign is_div   = lat_funct3[2];
  assign signed_a = (lat_funct3 == 3'd1) || (lat_funct3 == 3'd2) ||
                    (lat_funct3 == 3'd4) || (lat_funct3 == 3'd6);
  assign signed_b = (lat_funct3 == 3'd1) || (lat_funct3 == 3'd4) ||
                    (lat_funct3 == 3'd6);
  assign neg_a    = signed_a & lat_a[WIDTH-1];
  assign neg_b    = signed_b & lat_b[WIDTH-1];
  assign mag_a    = neg_a ? -lat_a : lat_a;
  assign mag_b    = neg_b ? -lat_b : lat_b;

  // ---------------------------------------------------------------------------
  // One iteration step of each algorithm
  // ---------------------------------------------------------------------------
  // Multiply: add the multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole register right by one. The
  // carry out of the add becomes the new MSB.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    {1'b0, addend & {WIDTH{acc[0]}}};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: shift the next dividend bit (MSB of the low half) into the
  // remainder, trial-subtract the divisor and keep the difference when it
  // does not go negative. The quotient bit enters at the bottom of the low half.
  // The remainder is always below the divisor, so the shifted value needs one
  // extra bit but the kept difference fits in WIDTH bits.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, addend};
  assign div_diff  = div_shift[WIDTH-1:0] - addend;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        stall = start & ~kill;
        if (start && !kill) begin
          next_state = PREP;
        end
      end
      PREP: begin
        stall      = ~kill;
        next_state = kill ? IDLE : ITER;
      end
      ITER: begin
        stall = ~kill;
        if (kill) begin
          next_state = IDLE;
        end else if (count == '0) begin
          next_state = FIN;
        end
      end
      FIN: begin
        // start is ignored here; the held instruction advances this cycle.
        done       = ~kill;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: reset clears every register (no storage arrays here), so rd_out and
  // the datapath read as zero straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_funct3 <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_rd     <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      addend     <= '0;
      acc        <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            lat_funct3 <= funct3;
            lat_a      <= op_a;
            lat_b      <= op_b;
            lat_rd     <= rd_in;
          end
        end
        PREP: begin
          sign_a <= neg_a;
          sign_b <= neg_b;
          // Low half holds the multiplier (mul) or the dividend (div);
          // the high half is the cleared accumulator / remainder.
          acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          addend <= is_div ? mag_b : mag_a;
          count  <= CW'(WIDTH - 1);
        end
        ITER: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result selection (only meaningful in FIN)
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               b_zero;

  // For MULHSU sign_b is never set, so the xor reduces to sign_a.
  assign prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
  assign quo        = acc[WIDTH-1:0];
  assign rem        = acc[2*WIDTH-1:WIDTH];
  assign b_zero     = (lat_b == '0);

  always_comb begin
    result = '0;
    if (done) begin
      case (lat_funct3)
        3'd0:              result = prod_fixed[WIDTH-1:0];
        3'd1, 3'd2, 3'd3:  result = prod_fixed[2*WIDTH-1:WIDTH];
        3'd4, 3'd5: begin
          // Divide by zero returns all ones regardless of signs.
          if (b_zero) begin
            result = '1;
          end else begin
            result = (sign_a ^ sign_b) ? -quo : quo;
          end
        end
        default: begin
          // Remainder by zero returns the original dividend untouched.
          if (b_zero) begin
            result = lat_a;
          end else begin
            result = sign_a ? -rem : rem;
          end
        end
      endcase
    end
  end

  assign rd_out    = lat_rd;
  assign reg_write = done & (lat_rd != '0);

endmodule
